// File: rtl/mux_iact_pkg.sv
// Shared definitions for the registered iact stream mux: FSM state encoding
// and the channel-select width helper.
package mux_iact_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One extra code point above the channel range encodes "disabled".
  function automatic int sel_width(input int i_count);
    return $clog2(i_count + 1);
  endfunction

endpackage

// File: rtl/iact_skid_buf.sv
// Two-entry valid/ready register slice. The head entry drives the output
// directly, so data and valid leave straight from flops. The second entry
// absorbs one beat while downstream stalls. The caller qualifies push
// (it only pushes when count < 2).
module iact_skid_buf
  import mux_iact_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [1:0]       count_q, count_d;
  logic             valid_q, valid_d;
  logic             pop;

  assign pop = valid_q & ready_i;

  // FIFO bookkeeping: the head is always the oldest beat, the skid entry the newer one
  always_comb begin
    head_d  = head_q;
    skid_d  = skid_q;
    count_d = count_q;
    case ({push_i, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = data_i;
        else                 skid_d = data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // With one entry left the head keeps its value so a_o stays quiet.
        if (count_q == 2'd2) head_d = skid_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = skid_q;
          skid_d = data_i;
        end
      end
      default: ;
    endcase
    valid_d = (count_d != 2'd0);
  end

  // Storage and occupancy registers; reset discards any buffered beats
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      skid_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      skid_q  <= skid_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/mux_iact_pipe.sv
// Registered N-channel iact stream mux with hazard-free channel switching.
// The selected channel feeds a 2-entry skid buffer; a channel change waits
// until the buffer has drained so beats of the old and new channel never mix.
// Optional feature macro: MUX_IACT_BEAT_CNT_EN (saturating output-beat counter).
module mux_iact_pipe
  import mux_iact_pkg::*;
#(
  parameter int WIDTH       = 20,
  parameter int I_COUNT     = 3,
  parameter bit UNSEL_READY = 1'b1,
  parameter int CNT_W       = 16,
  localparam int SEL_W      = sel_width(I_COUNT)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [WIDTH*I_COUNT-1:0] a_i,
  input  logic [I_COUNT-1:0]       b_i,
  output logic [I_COUNT-1:0]       c_o,
  output logic [WIDTH-1:0]         a_o,
  output logic                     b_o,
  input  logic                     c_i,
  output logic [SEL_W-1:0]         act_sel_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         beat_cnt_o
);

  localparam logic [SEL_W-1:0] SEL_OFF = SEL_W'(I_COUNT);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [1:0]       count;
  logic             sel_match;
  logic             sel_in_range;
  logic             act_ready;
  logic             push;
  logic             mux_valid;
  logic [WIDTH-1:0] mux_data;

  assign sel_match    = (sel_i == sel_q);
  assign sel_in_range = (sel_i < SEL_OFF);
  // Active channel is blocked the moment sel_i moves away, not a cycle later.
  assign act_ready    = (state_q == PASS) && sel_match && (count != 2'd2);
  assign push         = act_ready & mux_valid;

  // Input mux; a disabled sel_q matches no channel, so nothing is X-indexed
  always_comb begin
    mux_data  = '0;
    mux_valid = 1'b0;
    for (int j = 0; j < I_COUNT; j++) begin
      if (sel_q == SEL_W'(j)) begin
        mux_data  = a_i[j*WIDTH +: WIDTH];
        mux_valid = b_i[j];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < I_COUNT; gi++) begin : g_ready
      assign c_o[gi] = (sel_q == SEL_W'(gi)) ? act_ready : UNSEL_READY;
    end
  endgenerate

  // Next-state logic: a switch commits only once the buffer is empty;
  // an already-empty buffer lets the switch commit without a DRAIN cycle
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      OFF: begin
        if (sel_in_range) begin
          sel_d   = sel_i;
          state_d = PASS;
        end
      end
      PASS, DRAIN: begin
        if (sel_match) begin
          state_d = PASS;
        end else if (count == 2'd0) begin
          sel_d   = sel_i;
          state_d = sel_in_range ? PASS : OFF;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = OFF;
    endcase
  end

  // State and active-channel registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OFF;
      sel_q   <= SEL_OFF;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  iact_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (mux_data),
    .ready_i (c_i),
    .data_o  (a_o),
    .valid_o (b_o),
    .count_o (count)
  );

  assign act_sel_o = sel_q;
  assign busy_o    = (state_q == DRAIN);

`ifdef MUX_IACT_BEAT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Output beats since the last channel change, saturating; a change wins over a beat
  always_comb begin
    cnt_d = cnt_q;
    if (sel_d != sel_q)
      cnt_d = '0;
    else if (b_o && c_i && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Beat counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign beat_cnt_o = cnt_q;
`else
  assign beat_cnt_o = '0;
`endif

endmodule
